// File: rtl/bp_pkg.sv
// Branch-prediction shared definitions: default widths, PC step and the
// ID/EX branch metadata record used by the resolve unit, predictor and BTB.
package bp_pkg;

    localparam int XLEN_DEF = 32;
    localparam int PC_INC   = 4;

    typedef struct packed {
        logic                v;
        logic [XLEN_DEF-1:0] pc;
        logic                pred_taken;
        logic [XLEN_DEF-1:0] pred_target;
    } br_meta_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID->EX branch resolution: holds the predictor's decision, detects mispredicts
// in EX, produces the fetch redirect, predictor training pulses and statistics.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int XLEN  = bp_pkg::XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush_in,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             id_predict_taken,
    input  logic [XLEN-1:0]  id_pred_target,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    output logic             ex_branch_valid,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             upd_is_branch,
    output logic             upd_taken,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_mispredict
);

    // The metadata record is sized by the package, so the core width must match it.
    if (XLEN != XLEN_DEF) begin : g_xlen_check
        $error("branch_resolve_unit: XLEN must equal bp_pkg::XLEN_DEF");
    end

    br_meta_t ex_q;
    logic     live;
    logic     mismatch;

    // A branch is resolved exactly once: in the first EX cycle that is neither
    // stalled nor flushed. upd_is_branch/upd_taken are single-cycle pulses with
    // no back-pressure; the predictor must accept them in that cycle.
    assign live            = ex_q.v & ~stall & ~flush_in;
    assign ex_branch_valid = ex_q.v & ~flush_in;

    assign mismatch = (ex_q.pred_taken != ex_taken) |
                      (ex_q.pred_taken & ex_taken & (ex_q.pred_target != ex_target));

    assign mispredict    = live & mismatch;
    assign upd_is_branch = live;
    assign upd_taken     = live & ex_taken;

    always_comb begin
        redirect_pc = '0;
        if (mispredict) begin
            redirect_pc = ex_taken ? ex_target : (ex_q.pc + XLEN_DEF'(PC_INC));
        end
    end

    // A mispredict kills the wrong-path instruction sitting in ID this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else if (flush_in || mispredict) begin
            ex_q <= '0;
        end else if (!stall) begin
            ex_q.v           <= id_valid & id_is_branch;
            ex_q.pc          <= id_pc;
            ex_q.pred_taken  <= id_predict_taken;
            ex_q.pred_target <= id_pred_target;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_branch (
        .clk   (clk),
        .rst   (rst),
        .inc   (live),
        .count (cnt_branch)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_mispredict (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict),
        .count (cnt_mispredict)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue-based scoreboard on the
// predictor update pulse; counters use a 4-bit width so saturation is reachable.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             flush_in;
    logic             id_valid;
    logic             id_is_branch;
    logic [XLEN-1:0]  id_pc;
    logic             id_predict_taken;
    logic [XLEN-1:0]  id_pred_target;
    logic             ex_taken;
    logic [XLEN-1:0]  ex_target;
    logic             ex_branch_valid;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic             upd_is_branch;
    logic             upd_taken;
    logic [CNT_W-1:0] cnt_branch;
    logic [CNT_W-1:0] cnt_mispredict;

    // Expected update record: {mispredict, upd_taken, redirect_pc}
    logic [XLEN+1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_br   = 0;
    int exp_mis  = 0;

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush_in         (flush_in),
        .id_valid         (id_valid),
        .id_is_branch     (id_is_branch),
        .id_pc            (id_pc),
        .id_predict_taken (id_predict_taken),
        .id_pred_target   (id_pred_target),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_branch_valid  (ex_branch_valid),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .upd_is_branch    (upd_is_branch),
        .upd_taken        (upd_taken),
        .cnt_branch       (cnt_branch),
        .cnt_mispredict   (cnt_mispredict)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [XLEN+1:0] exp;
        if (upd_is_branch) begin
            if (exp_q.size() == 0) begin
                check("unexpected_update", 64'(upd_is_branch), 64'd0);
            end else begin
                exp = exp_q.pop_front();
                check("update_record", 64'({mispredict, upd_taken, redirect_pc}), 64'(exp));
            end
        end else begin
            check("idle_no_redirect", 64'({mispredict, upd_taken, redirect_pc}), 64'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        stall = 0; flush_in = 0; id_valid = 0; id_is_branch = 0; id_pc = '0;
        id_predict_taken = 0; id_pred_target = '0; ex_taken = 0; ex_target = '0;
    endtask

    task automatic bump_model(input logic mis);
        exp_br = (exp_br == CMAX) ? CMAX : exp_br + 1;
        if (mis) exp_mis = (exp_mis == CMAX) ? CMAX : exp_mis + 1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt_branch"}, 64'(cnt_branch), 64'(exp_br));
        check({tag, "_cnt_mispredict"}, 64'(cnt_mispredict), 64'(exp_mis));
    endtask

    // Branch in ID for one cycle, resolved in EX the next cycle. wp drives a
    // wrong-path branch into ID during the EX cycle.
    task automatic issue_branch(input logic [XLEN-1:0] pc, input logic pred,
                                input logic [XLEN-1:0] ptgt, input logic taken,
                                input logic [XLEN-1:0] tgt, input logic exp_m,
                                input logic [XLEN-1:0] exp_red, input logic wp);
        @(posedge clk); #1;
        id_valid = 1; id_is_branch = 1; id_pc = pc;
        id_predict_taken = pred; id_pred_target = ptgt;
        @(posedge clk); #1;
        id_valid = wp; id_is_branch = wp; id_pc = pc + 32'd4;
        id_predict_taken = 0; id_pred_target = '0;
        ex_taken = taken; ex_target = tgt;
        exp_q.push_back({exp_m, taken, exp_red});
        @(posedge clk); #1;
        idle_inputs();
        bump_model(exp_m);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ex_valid", 64'(ex_branch_valid), 64'd0);
        check("reset_outputs", 64'({mispredict, upd_is_branch, upd_taken, redirect_pc}), 64'd0);
        check_counts("reset");
        @(posedge clk); #1;
        rst = 0;

        // correct not-taken
        issue_branch(32'h100, 0, 32'h0, 0, 32'h104, 0, 32'h0, 0);
        check_counts("nt_correct");

        // predicted not-taken, actually taken; wrong-path ID branch must be killed
        issue_branch(32'h200, 0, 32'h0, 1, 32'h180, 1, 32'h180, 1);
        check_counts("nt_to_t");
        @(negedge clk);
        check("wrong_path_killed", 64'(ex_branch_valid), 64'd0);

        // predicted taken, not taken, PC+4 wraps
        issue_branch(32'hFFFF_FFFC, 1, 32'h300, 0, 32'h0, 1, 32'h0, 0);
        check_counts("t_to_nt_wrap");

        // predicted taken with correct target
        issue_branch(32'h400, 1, 32'h500, 1, 32'h500, 0, 32'h0, 0);
        check_counts("t_correct");

        // both taken, target differs
        issue_branch(32'h600, 1, 32'h700, 1, 32'h704, 1, 32'h704, 0);
        check_counts("target_miss");

        // non-branch in ID loads an empty entry
        @(posedge clk); #1;
        id_valid = 1; id_is_branch = 0; id_pc = 32'h680;
        @(posedge clk); #1;
        idle_inputs(); ex_taken = 1; ex_target = 32'h900;
        @(negedge clk);
        check("non_branch_ex_valid", 64'(ex_branch_valid), 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        check_counts("non_branch");

        // stall three cycles in EX, resolve on release
        @(posedge clk); #1;
        id_valid = 1; id_is_branch = 1; id_pc = 32'h800; id_predict_taken = 0;
        @(posedge clk); #1;
        id_valid = 0; id_is_branch = 0; stall = 1; ex_taken = 1; ex_target = 32'h900;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ex_valid", 64'(ex_branch_valid), 64'd1);
            @(posedge clk); #1;
        end
        stall = 0;
        exp_q.push_back({1'b1, 1'b1, 32'h900});
        @(posedge clk); #1;
        idle_inputs();
        bump_model(1);
        check_counts("stall_release");

        // flush with stall and a mismatching branch in EX
        @(posedge clk); #1;
        id_valid = 1; id_is_branch = 1; id_pc = 32'hA00; id_predict_taken = 0;
        @(posedge clk); #1;
        id_valid = 0; id_is_branch = 0; stall = 1; flush_in = 1;
        ex_taken = 1; ex_target = 32'hB00;
        @(negedge clk);
        check("flush_ex_valid", 64'(ex_branch_valid), 64'd0);
        @(posedge clk); #1;
        stall = 0; flush_in = 0;
        @(negedge clk);
        check("flush_cleared", 64'(ex_branch_valid), 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        check_counts("flush");

        // drive counters into saturation with repeated mispredicts
        for (int i = 0; i < 12; i++) begin
            issue_branch(32'h1000, 0, 32'h0, 1, 32'h2000, 1, 32'h2000, 0);
        end
        check_counts("saturate");
        check("sat_mis_all_ones", 64'(cnt_mispredict), 64'hF);

        // reset while a mismatching branch is stalled in EX
        @(posedge clk); #1;
        id_valid = 1; id_is_branch = 1; id_pc = 32'hC00; id_predict_taken = 0;
        @(posedge clk); #1;
        id_valid = 0; id_is_branch = 0; stall = 1; ex_taken = 1; ex_target = 32'hD00;
        @(negedge clk);
        check("pre_reset_ex_valid", 64'(ex_branch_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        exp_br = 0; exp_mis = 0;
        check("midstall_reset_outputs",
              64'({ex_branch_valid, mispredict, upd_is_branch, upd_taken, redirect_pc}), 64'd0);
        check_counts("midstall_reset");
        stall = 0;
        @(negedge clk);
        check("post_reset_ex_valid", 64'(ex_branch_valid), 64'd0);
        @(posedge clk); #1;
        idle_inputs();

        // counting restarts after reset
        issue_branch(32'h100, 0, 32'h0, 0, 32'h104, 0, 32'h0, 0);
        check_counts("after_reset");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
